// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, FSM states and the operand bundle for the register-file port controller.
package rf_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [DATA_W-1:0] ZERO_W = '0;
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
    } op_t;
endpackage

// File: rtl/rf_port_ctrl.sv
// rf_port_ctrl: arbitrates writeback vs operand reads onto the regfile port and returns operands to issue.
// Optional RF_HOLD_BYPASS_EN: writebacks to captured source registers update held operands.
module rf_port_ctrl #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int MAX_WB_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_rs1,
    input  logic [ADDR_W-1:0] rd_rs2,
    input  logic [ADDR_W-1:0] rd_rs3,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_c,
    output logic              rf_enable,
    output logic              rf_write,
    output logic              rf_read,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    output logic [ADDR_W-1:0] rf_waddr1,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,
    input  logic [DATA_W-1:0] rf_dout3
);
    import rf_pkg::*;

    localparam int SW = $clog2(MAX_WB_STREAK + 1);

    state_t state, state_n;
    op_t op_q, op_n;
    logic [SW-1:0] streak;
    logic wb_block, wb_fire, rd_fire;
`ifdef RF_HOLD_BYPASS_EN
    logic [ADDR_W-1:0] rs1_q, rs2_q, rs3_q;
`endif

    // A read starved by MAX_WB_STREAK write wins gets the port for one cycle
    assign wb_block = state == IDLE && rd_req_valid && streak == SW'(MAX_WB_STREAK);
    assign wb_ready = !rst && !wb_block;
    assign wb_fire = wb_valid && wb_ready;
    assign rd_req_ready = !rst && state == IDLE && !wb_fire;
    assign rd_fire = rd_req_valid && rd_req_ready;

    assign rf_enable = wb_fire || rd_fire;
    assign rf_write = wb_fire;
    assign rf_read = rd_fire;
    assign rf_raddr1 = rd_fire ? rd_rs1 : '0;
    assign rf_raddr2 = rd_fire ? rd_rs2 : '0;
    assign rf_waddr1 = wb_fire ? wb_addr : rd_fire ? rd_rs3 : '0;
    assign rf_din = wb_fire ? wb_data : ZERO_W;

    assign op_valid = state == OUT;
    assign op_a = op_q.a;
    assign op_b = op_q.b;
    assign op_c = op_q.c;

    always_comb begin
        state_n = rd_fire ? WAIT : state == WAIT ? OUT : (state == OUT && op_ready) ? IDLE : state;
        op_n = state == WAIT ? {rf_dout1, rf_dout2, rf_dout3} : op_q;
`ifdef RF_HOLD_BYPASS_EN
        op_n.a = (wb_fire && state != IDLE && wb_addr == rs1_q) ? wb_data : op_n.a;
        op_n.b = (wb_fire && state != IDLE && wb_addr == rs2_q) ? wb_data : op_n.b;
        op_n.c = (wb_fire && state != IDLE && wb_addr == rs3_q) ? wb_data : op_n.c;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q <= '0;
            streak <= '0;
        end else begin
            state <= state_n;
            op_q <= op_n;
            if (rd_fire || (state == IDLE && !rd_req_valid))
                streak <= '0;
            else if (state == IDLE && wb_fire && streak != SW'(MAX_WB_STREAK))
                streak <= streak + SW'(1);
        end
    end

`ifdef RF_HOLD_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q <= '0;
            rs2_q <= '0;
            rs3_q <= '0;
        end else if (rd_fire) begin
            rs1_q <= rd_rs1;
            rs2_q <= rd_rs2;
            rs3_q <= rd_rs3;
        end
    end
`endif
endmodule

// File: tb/tb_rf_port_ctrl.sv
// tb_rf_port_ctrl: scoreboard bench with a behavioural registered-read regfile attached to rf_port_ctrl.
module tb_rf_port_ctrl;
    import rf_pkg::*;

`ifdef RF_HOLD_BYPASS_EN
    localparam logic [31:0] BYP_B = 32'hBEEF;
`else
    localparam logic [31:0] BYP_B = 32'h22;
`endif

    logic clk = 0;
    logic rst = 1;
    logic rd_req_valid = 0, rd_req_ready;
    logic [4:0] rd_rs1 = 0, rd_rs2 = 0, rd_rs3 = 0;
    logic wb_valid = 0, wb_ready;
    logic [4:0] wb_addr = 0;
    logic [31:0] wb_data = 0;
    logic op_valid, op_ready = 0;
    logic [31:0] op_a, op_b, op_c;
    logic rf_enable, rf_write, rf_read;
    logic [4:0] rf_raddr1, rf_raddr2, rf_waddr1;
    logic [31:0] rf_din, rf_dout1, rf_dout2, rf_dout3;

    int pass_cnt = 0;
    int total_cnt = 0;
    op_t exp_q[$];
    logic [31:0] mem [32];

    rf_port_ctrl #(.DATA_W(32), .ADDR_W(5), .MAX_WB_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_rs1(rd_rs1), .rd_rs2(rd_rs2), .rd_rs3(rd_rs3),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .rf_enable(rf_enable), .rf_write(rf_write), .rf_read(rf_read),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr1(rf_waddr1),
        .rf_din(rf_din), .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_dout3(rf_dout3)
    );

    always #5 clk = ~clk;

    // Regfile: synchronous write, registered read data held until the next read
    always @(posedge clk) begin
        if (rf_enable && rf_write)
            mem[rf_waddr1] <= rf_din;
        else if (rf_enable && rf_read) begin
            rf_dout1 <= mem[rf_raddr1];
            rf_dout2 <= mem[rf_raddr2];
            rf_dout3 <= mem[rf_waddr1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every operand consumption is compared against the oldest expected bundle
    always @(negedge clk) begin
        if (!rst && op_valid && op_ready) begin
            if (exp_q.size() == 0) check("op_unexpected", 1, 0);
            else begin
                op_t e;
                e = exp_q.pop_front();
                check("op_a", op_a, e.a);
                check("op_b", op_b, e.b);
                check("op_c", op_c, e.c);
            end
        end
    end

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1; wb_addr = a; wb_data = d;
        @(posedge clk); #1 wb_valid = 0;
    endtask

    task automatic issue_read(input logic [4:0] a1, a2, a3, input logic [31:0] ea, eb, ec);
        bit ok;
        ok = 0;
        rd_req_valid = 1; rd_rs1 = a1; rd_rs2 = a2; rd_rs3 = a3;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rd_req_ready) begin
                exp_q.push_back('{a: ea, b: eb, c: ec});
                ok = 1;
            end
        end
        if (!ok) check("rd_accept_timeout", 0, 1);
        @(posedge clk); #1 rd_req_valid = 0;
    endtask

    task automatic wait_op();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = op_valid;
        end
        if (!ok) check("op_valid_timeout", 0, 1);
    endtask

    task automatic consume();
        @(posedge clk); #1 op_ready = 1;
        @(posedge clk); #1 op_ready = 0;
    endtask

    initial begin
        int bad;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_req_ready", rd_req_ready, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_rf_enable", rf_enable, 0);
        check("rst_op_a", op_a, 0);
        rst = 0;
        @(posedge clk); #1;
        wb_write(3, 32'h11);
        wb_write(4, 32'h22);
        wb_write(5, 32'h33);
        @(negedge clk);
        check("idle_rf_enable", rf_enable, 0);
        check("idle_rf_waddr1", rf_waddr1, 0);
        check("idle_rf_din", rf_din, 0);
        @(posedge clk); #1;

        // Basic read with latency and hold
        issue_read(3, 4, 5, 32'h11, 32'h22, 32'h33);
        @(negedge clk); check("lat_t1_op_valid", op_valid, 0);
        @(negedge clk); check("lat_t2_op_valid", op_valid, 1);
        repeat (3) @(negedge clk);
        check("hold_op_valid", op_valid, 1);
        check("hold_op_a", op_a, 32'h11);
        consume();
        @(negedge clk); check("after_consume_op_valid", op_valid, 0);

        // Collision: write wins, read follows
        @(posedge clk); #1;
        wb_valid = 1; wb_addr = 7; wb_data = 32'hDEAD;
        rd_req_valid = 1; rd_rs1 = 7; rd_rs2 = 3; rd_rs3 = 4;
        @(negedge clk);
        check("col_rf_write", rf_write, 1);
        check("col_rf_read", rf_read, 0);
        check("col_rd_req_ready", rd_req_ready, 0);
        check("col_rf_waddr1", rf_waddr1, 7);
        check("col_rf_din", rf_din, 32'hDEAD);
        @(posedge clk); #1 wb_valid = 0;
        @(negedge clk);
        check("col_next_rf_read", rf_read, 1);
        check("col_next_raddr1", rf_raddr1, 7);
        check("col_next_waddr1", rf_waddr1, 4);
        if (rd_req_ready) exp_q.push_back('{a: 32'hDEAD, b: 32'h11, c: 32'h22});
        else check("col_next_rd_req_ready", rd_req_ready, 1);
        @(posedge clk); #1 rd_req_valid = 0;
        wait_op();
        consume();

        // Starvation guard
        @(posedge clk); #1;
        wb_valid = 1; wb_addr = 10; wb_data = 32'h100;
        rd_req_valid = 1; rd_rs1 = 10; rd_rs2 = 3; rd_rs3 = 5;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stv_wb_ready", wb_ready, 1);
            check("stv_rd_req_ready", rd_req_ready, 0);
            @(posedge clk); #1 wb_data = 32'h101 + k;
        end
        @(negedge clk);
        check("stv5_wb_ready", wb_ready, 0);
        check("stv5_rf_write", rf_write, 0);
        check("stv5_rf_read", rf_read, 1);
        if (rd_req_ready) exp_q.push_back('{a: 32'h103, b: 32'h11, c: 32'h33});
        else check("stv5_rd_req_ready", rd_req_ready, 1);
        @(posedge clk); #1 wb_valid = 0; rd_req_valid = 0;
        wait_op();
        consume();
        @(posedge clk); #1;
        wb_valid = 1; wb_addr = 11; wb_data = 32'h55;
        rd_req_valid = 1; rd_rs1 = 3; rd_rs2 = 4; rd_rs3 = 5;
        @(negedge clk);
        check("streak_reset_wb_ready", wb_ready, 1);
        @(posedge clk); #1 wb_valid = 0;
        issue_read(3, 4, 5, 32'h11, 32'h22, 32'h33);
        wait_op();
        consume();

        // Backpressure with unrelated writes
        @(posedge clk); #1;
        issue_read(3, 4, 5, 32'h11, 32'h22, 32'h33);
        wait_op();
        @(posedge clk); #1;
        rd_req_valid = 1; wb_valid = 1; wb_addr = 9;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            wb_data = 32'h900 + i;
            @(negedge clk);
            if (op_a !== 32'h11 || op_b !== 32'h22 || op_c !== 32'h33 || rd_req_ready !== 0 || op_valid !== 1)
                bad++;
            @(posedge clk); #1;
        end
        check("bp_bad_cycles", bad, 0);
        rd_req_valid = 0; wb_valid = 0;
        consume();

        // Held-operand bypass
        @(posedge clk); #1;
        issue_read(3, 4, 5, 32'h11, BYP_B, 32'h33);
        wait_op();
        @(posedge clk); #1;
        wb_write(4, 32'hBEEF);
        @(negedge clk);
        check("byp_op_b", op_b, BYP_B);
        check("byp_op_a", op_a, 32'h11);
        consume();

        // Reset in WAIT
        @(posedge clk); #1;
        issue_read(7, 4, 3, 32'hDEAD, 32'hBEEF, 32'h11);
        rst = 1;
        #1;
        check("rstw_op_valid", op_valid, 0);
        check("rstw_rf_enable", rf_enable, 0);
        check("rstw_rd_req_ready", rd_req_ready, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rstw_op_valid_hold", op_valid, 0);
        check("rstw_op_a", op_a, 0);
        rst = 0;
        @(posedge clk); #1;
        issue_read(7, 4, 3, 32'hDEAD, 32'hBEEF, 32'h11);
        wait_op();
        consume();

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/rf_port_ctrl.md
Name: rf_port_ctrl

Overview:
- Initiator side of the pipeline register-file port: it drives enable/write/read, the two read addresses, the shared waddr1 address and din.
- Accepts operand-read requests from decode (valid/ready) and writeback requests from WB (valid/ready).
- Arbitrates between them: only one of write or read may be issued per cycle, and write wins.
- Returns captured operands to the issue stage with a valid/ready handshake.

Parameters:
- DATA_W, 32, register data width (RegBus)
- ADDR_W, 5, register address width (RegAddrBus)
- MAX_WB_STREAK, 4, consecutive write-won cycles against a pending read before one write cycle is blocked

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rd_req_valid  in  1  operand read request
- rd_req_ready  out  1  request accepted this cycle
- rd_rs1  in  ADDR_W  source 1 address
- rd_rs2  in  ADDR_W  source 2 address
- rd_rs3  in  ADDR_W  source 3 address (store data); driven onto rf_waddr1 during read
- wb_valid  in  1  writeback request
- wb_ready  out  1  writeback accepted this cycle
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- op_valid  out  1  operands valid
- op_ready  in  1  issue stage consumes operands
- op_a  out  DATA_W  operand from rs1
- op_b  out  DATA_W  operand from rs2
- op_c  out  DATA_W  operand from rs3
- rf_enable  out  1  regfile enable, active-high
- rf_write  out  1  regfile write strobe, active-high
- rf_read  out  1  regfile read strobe, active-high
- rf_raddr1  out  ADDR_W  regfile read address 1
- rf_raddr2  out  ADDR_W  regfile read address 2
- rf_waddr1  out  ADDR_W  wb_addr when writing, rd_rs3 when reading
- rf_din  out  DATA_W  wb_data
- rf_dout1  in  DATA_W  regfile registered read data 1
- rf_dout2  in  DATA_W  regfile registered read data 2
- rf_dout3  in  DATA_W  regfile registered read data 3

Behaviour:
- Regfile model:
  - Synchronous write.
  - Read data is registered: it is valid the cycle after rf_read is sampled and holds until the next read.
  - Write has priority inside the regfile when both strobes are asserted; this block never asserts both.
- FSM states: IDLE, WAIT, OUT.
  - IDLE: rd_req_ready = !wb_fire. On rd_req_valid && rd_req_ready, drive rf_enable=1, rf_read=1, rf_raddr1=rs1, rf_raddr2=rs2, rf_waddr1=rs3, then go to WAIT.
  - WAIT: one cycle. Capture rf_dout1/2/3 into op_a/b/c at the end of the cycle, then go to OUT.
  - OUT: op_valid=1 and operands are held stable. On op_ready, go to IDLE. There is no accept in the same cycle; the next request can be accepted the following cycle.
- Latency: request accepted at the edge ending cycle t gives op_valid high from cycle t+2.
- Writeback:
  - wb_fire = wb_valid && wb_ready.
  - When firing, drive rf_enable=1, rf_write=1, rf_waddr1=wb_addr, rf_din=wb_data. rf_read is forced to 0.
  - Writes may fire in any state.
- wb_ready rules:
  - wb_ready is 1 except when the streak counter equals MAX_WB_STREAK in IDLE with rd_req_valid high. In that case wb_ready=0 and the read is issued.
  - The streak counter increments on each cycle that is IDLE, rd_req_valid and wb_fire, and saturates at MAX_WB_STREAK.
  - It clears on any read accept, or on any IDLE cycle without rd_req_valid.
- Idle drive: when neither write nor read is issued, all rf_* outputs are 0 (addresses and din are also 0).
- Reset (async, any state): state=IDLE, streak=0, op_a/b/c=0, op_valid=0, rf_enable/write/read=0, rd_req_ready=0 while rst is asserted. Any in-flight read is discarded.

Optional Feature:
- Macro: RF_HOLD_BYPASS_EN.
- Defined: in WAIT or OUT, a firing writeback whose wb_addr matches the captured rs1, rs2 or rs3 updates the matching op_a/op_b/op_c with wb_data at that edge. In WAIT, the write overrides the rf_dout value being captured. Multiple fields can match simultaneously.
- Undefined: held operands are never modified after capture.

Decomposition:
- Package rf_pkg holds:
  - DATA_W and ADDR_W constants
  - the FSM state enum (IDLE/WAIT/OUT)
  - a zero-word constant
  - an operand bundle struct {a, b, c}
- No sub-module: the arbiter, FSM and capture registers stay in one module.

Test Plan:
- Basic read: preload r3=0x11, r4=0x22, r5=0x33; request rs1=3, rs2=4, rs3=5 with no wb -> op_valid at t+2, op_a=0x11, op_b=0x22, op_c=0x33; held until op_ready.
- Collision: wb_valid (addr 7, 0xDEAD) and rd_req_valid in the same cycle -> rf_write=1, rf_read=0, rd_req_ready=0; read issues next cycle; a later read of r7 returns 0xDEAD.
- Starvation guard: wb_valid held high with MAX_WB_STREAK=4 and rd_req_valid high -> 4 writes fire, wb_ready=0 in the 5th cycle, read accepted; streak resets.
- Backpressure: op_ready=0 for 10 cycles while writes target unrelated r9 -> operands unchanged, rd_req_ready=0 throughout.
- Bypass (RF_HOLD_BYPASS_EN): in OUT with rs2=4, write r4=0xBEEF -> op_b becomes 0xBEEF the next cycle. Without the macro, op_b stays 0x22.
- Reset mid-WAIT: assert rst -> op_valid=0, rf_* = 0 immediately; after release, a fresh request completes normally.
